// File: rtl/cordic_prerotate_pkg.sv
// Shared CORDIC constants: octant codes, turn fractions of a PW-bit phase, width sanity check.
// Pure declarations, no timing.
package cordic_prerotate_pkg;

  localparam logic [2:0] OCT_000 = 3'b000;
  localparam logic [2:0] OCT_001 = 3'b001;
  localparam logic [2:0] OCT_010 = 3'b010;
  localparam logic [2:0] OCT_011 = 3'b011;
  localparam logic [2:0] OCT_100 = 3'b100;
  localparam logic [2:0] OCT_101 = 3'b101;
  localparam logic [2:0] OCT_110 = 3'b110;
  localparam logic [2:0] OCT_111 = 3'b111;

  // 90 degrees in a full-circle phase word of width pw
  function automatic logic [31:0] quarter_turn(input int pw);
    return 32'd1 << (pw - 2);
  endfunction

  function automatic logic [31:0] half_turn(input int pw);
    return 32'd1 << (pw - 1);
  endfunction

  // one headroom bit above the sign plus at least one guard bit
  function automatic bit widths_ok(input int iw, input int ww);
    return ww >= iw + 2;
  endfunction

endpackage

// File: rtl/cordic_widen.sv
// Widens x/y to WW bits (headroom + guard bits) and registers them with phase and aux.
// Latency 1 i_ce cycle; no backpressure, i_ce low holds every register.
module cordic_widen
  import cordic_prerotate_pkg::*;
#(
  parameter int IW = 12,
  parameter int WW = 15,
  parameter int PW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  input  logic        [PW-1:0] i_phase,
  input  logic                 i_aux,
  output logic signed [WW-1:0] o_xval,
  output logic signed [WW-1:0] o_yval,
  output logic        [PW-1:0] o_phase,
  output logic                 o_aux
);

  logic signed [WW-1:0] xw;
  logic signed [WW-1:0] yw;

  assign xw = {i_xval[IW-1], i_xval, {(WW-IW-1){1'b0}}};
  assign yw = {i_yval[IW-1], i_yval, {(WW-IW-1){1'b0}}};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_xval  <= '0;
      o_yval  <= '0;
      o_phase <= '0;
      o_aux   <= 1'b0;
    end else if (i_ce) begin
      o_xval  <= xw;
      o_yval  <= yw;
      o_phase <= i_phase;
      o_aux   <= i_aux;
    end
  end

endmodule

// File: rtl/cordic_prerotate.sv
// Widens samples, then pre-rotates by a multiple of 90 deg so the residual phase is in [-45, +45).
// Latency 2 i_ce cycles; no backpressure, i_ce low freezes the whole pipeline.
module cordic_prerotate
  import cordic_prerotate_pkg::*;
#(
  parameter int IW = 12,
  parameter int WW = 15,
  parameter int PW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  input  logic        [PW-1:0] i_phase,
  input  logic                 i_aux,
  output logic signed [WW-1:0] o_xval,
  output logic signed [WW-1:0] o_yval,
  output logic        [PW-1:0] o_phase,
  output logic                 o_aux
);

  if (!widths_ok(IW, WW)) begin : g_bad_width
    $error("cordic_prerotate: WW must be at least IW+2");
  end

  localparam logic [PW-1:0] QTR  = PW'(quarter_turn(PW));
  localparam logic [PW-1:0] HALF = PW'(half_turn(PW));

  logic signed [WW-1:0] s1_x;
  logic signed [WW-1:0] s1_y;
  logic        [PW-1:0] s1_phase;
  logic                 s1_aux;

  cordic_widen #(.IW(IW), .WW(WW), .PW(PW)) u_widen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_xval  (i_xval),
    .i_yval  (i_yval),
    .i_phase (i_phase),
    .i_aux   (i_aux),
    .o_xval  (s1_x),
    .o_yval  (s1_y),
    .o_phase (s1_phase),
    .o_aux   (s1_aux)
  );

  logic signed [WW-1:0] rot_x;
  logic signed [WW-1:0] rot_y;
  logic        [PW-1:0] rot_phase;

  // headroom bit makes negation of the most-negative widened value safe
  always_comb begin
    rot_x     = s1_x;
    rot_y     = s1_y;
    rot_phase = s1_phase;
    case (s1_phase[PW-1 -: 3])
      OCT_001, OCT_010: begin
        rot_x     = -s1_y;
        rot_y     = s1_x;
        rot_phase = s1_phase - QTR;
      end
      OCT_011, OCT_100: begin
        rot_x     = -s1_x;
        rot_y     = -s1_y;
        rot_phase = s1_phase - HALF;
      end
      OCT_101, OCT_110: begin
        rot_x     = s1_y;
        rot_y     = -s1_x;
        rot_phase = s1_phase + QTR;
      end
      default: begin
        rot_x     = s1_x;
        rot_y     = s1_y;
        rot_phase = s1_phase;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_xval  <= '0;
      o_yval  <= '0;
      o_phase <= '0;
      o_aux   <= 1'b0;
    end else if (i_ce) begin
      o_xval  <= rot_x;
      o_yval  <= rot_y;
      o_phase <= rot_phase;
      o_aux   <= s1_aux;
    end
  end

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed bench for cordic_prerotate at IW=12, WW=15, PW=16 with hand-computed expectations.
module tb_cordic_prerotate;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_ce;
  logic signed [11:0] i_xval;
  logic signed [11:0] i_yval;
  logic        [15:0] i_phase;
  logic               i_aux;
  logic signed [14:0] o_xval;
  logic signed [14:0] o_yval;
  logic        [15:0] o_phase;
  logic               o_aux;

  int checks = 0;
  int errors = 0;
  int prev_x = 0;
  logic prev_aux = 1'b0;

  cordic_prerotate #(.IW(12), .WW(15), .PW(16)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_xval  (i_xval),
    .i_yval  (i_yval),
    .i_phase (i_phase),
    .i_aux   (i_aux),
    .o_xval  (o_xval),
    .o_yval  (o_yval),
    .o_phase (o_phase),
    .o_aux   (o_aux)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic [15:0] ph, input logic aux);
    i_xval  = 12'(x);
    i_yval  = 12'(y);
    i_phase = ph;
    i_aux   = aux;
  endtask

  task automatic chk15(input string tag, input logic [14:0] obs, input int exp);
    logic [14:0] e;
    e = 15'(exp);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // hold one sample for two enabled edges; after the first edge the previous result must still show
  task automatic run(input string tag, input int x, input int y, input logic [15:0] ph,
                     input logic aux, input int ex, input int ey, input logic [15:0] eph);
    drive(x, y, ph, aux);
    i_ce = 1'b1;
    tick();
    chk15({tag, "_lat_x"}, o_xval, prev_x);
    chk1({tag, "_lat_aux"}, o_aux, prev_aux);
    tick();
    chk15({tag, "_x"}, o_xval, ex);
    chk15({tag, "_y"}, o_yval, ey);
    chk16({tag, "_ph"}, o_phase, eph);
    chk1({tag, "_aux"}, o_aux, aux);
    prev_x   = ex;
    prev_aux = aux;
  endtask

  initial begin
    i_reset = 1'b1;
    i_ce    = 1'b0;
    drive(0, 0, 16'h0000, 1'b0);
    tick();
    tick();
    chk15("rst_x", o_xval, 0);
    chk15("rst_y", o_yval, 0);
    chk16("rst_ph", o_phase, 16'h0000);
    chk1("rst_aux", o_aux, 1'b0);
    i_reset = 1'b0;

    run("pass",   1000,     0, 16'h0000, 1'b1,  4000,     0, 16'h0000);
    run("q90",    1000,     0, 16'h4000, 1'b0,     0,  4000, 16'h0000);
    run("q180",   1000,     0, 16'h8000, 1'b1, -4000,     0, 16'h0000);
    run("q270",   1000,     0, 16'hC000, 1'b0,     0, -4000, 16'h0000);
    run("oct45",  1000,     0, 16'h2000, 1'b1,     0,  4000, 16'hE000);
    run("octE0",  1000,     0, 16'hE000, 1'b0,  4000,     0, 16'hE000);
    run("oct1F",  1000,     0, 16'h1FFF, 1'b1,  4000,     0, 16'h1FFF);
    run("oct1y",  1000,  -500, 16'h2000, 1'b0,  2000,  4000, 16'hE000);
    run("oct3y",  1000,   250, 16'h6000, 1'b1, -4000, -1000, 16'hE000);
    run("oct5y",  1000,   250, 16'hA000, 1'b0,  1000, -4000, 16'hE000);
    run("extreme",-2048, -2048, 16'h8000, 1'b1,  8192,  8192, 16'h0000);

    // i_ce pattern 1-0-0-1-1; the sample offered while disabled must never appear
    drive(100, 0, 16'h0000, 1'b0);
    i_ce = 1'b1;
    tick();
    chk15("ce_a_x", o_xval, 8192);
    drive(999, 0, 16'h0000, 1'b1);
    i_ce = 1'b0;
    tick();
    chk15("ce_hold1_x", o_xval, 8192);
    chk1("ce_hold1_aux", o_aux, 1'b1);
    tick();
    chk15("ce_hold2_x", o_xval, 8192);
    drive(200, 0, 16'h0000, 1'b1);
    i_ce = 1'b1;
    tick();
    chk15("ce_outa_x", o_xval, 400);
    chk1("ce_outa_aux", o_aux, 1'b0);
    drive(300, 0, 16'h0000, 1'b0);
    tick();
    chk15("ce_outb_x", o_xval, 800);
    chk1("ce_outb_aux", o_aux, 1'b1);
    tick();
    chk15("ce_outc_x", o_xval, 1200);

    // reset with i_ce low while two samples are in flight
    drive(500, 0, 16'h4000, 1'b1);
    tick();
    drive(600, 0, 16'h4000, 1'b1);
    tick();
    chk15("mid_e_y", o_yval, 2000);
    i_ce    = 1'b0;
    i_reset = 1'b1;
    tick();
    chk15("mid_rst_x", o_xval, 0);
    chk15("mid_rst_y", o_yval, 0);
    chk16("mid_rst_ph", o_phase, 16'h0000);
    chk1("mid_rst_aux", o_aux, 1'b0);
    i_reset = 1'b0;
    i_ce    = 1'b1;
    drive(700, 0, 16'h0000, 1'b1);
    tick();
    chk15("post_rst1_x", o_xval, 0);
    chk15("post_rst1_y", o_yval, 0);
    chk1("post_rst1_aux", o_aux, 1'b0);
    tick();
    chk15("post_rst2_x", o_xval, 2800);
    chk1("post_rst2_aux", o_aux, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
